// File: rtl/wr_ptr_ctrl.sv
// Write-domain pointer controller for the async FIFO: Gray/binary write
// pointer, read-pointer synchroniser, full/level/almost-full and overflow.
module wr_ptr_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic                  w_en,
    input  logic                  clr_ovf,
    input  logic [ADDR_WIDTH:0]   gray_rptr,
    output logic [ADDR_WIDTH:0]   binary_wptr,
    output logic [ADDR_WIDTH:0]   gray_wptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wr_fire,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AF_TH = PW'(AFULL_THRESH);

    logic [PW-1:0] rq_q [SYNC_STAGES];
    logic [PW-1:0] rq_sync;
    logic [PW-1:0] rbin_sync;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] full_tgt;
    logic [PW-1:0] wr_level_next;
    logic          full_next;
    logic          afull_next;
    logic          ovf_set;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rq_q[i] <= '0;
            end
        end else begin
            rq_q[0] <= gray_rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rq_q[i] <= rq_q[i-1];
            end
        end
    end

    assign rq_sync = rq_q[SYNC_STAGES-1];

    always_comb begin
        rbin_sync = '0;
        for (int i = 0; i < PW; i++) begin
            rbin_sync[i] = ^(rq_sync >> i);
        end
    end

    // No RAM strobe while the block is held in reset.
    assign wr_fire    = w_en & ~full & wrst_n;
    assign wbin_next  = binary_wptr + {{(PW-1){1'b0}}, wr_fire};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // Full when the write pointer is one lap ahead of the synced read pointer.
    assign full_tgt      = {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]};
    assign full_next     = (wgray_next == full_tgt);
    assign wr_level_next = wbin_next - rbin_sync;
    assign afull_next    = (wr_level_next >= AF_TH);
    assign ovf_set       = w_en & full;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            binary_wptr <= '0;
            gray_wptr   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            binary_wptr <= wbin_next;
            gray_wptr   <= wgray_next;
            full        <= full_next;
            almost_full <= afull_next;
            wr_level    <= wr_level_next;
            overflow    <= ovf_set | (overflow & ~clr_ovf);
        end
    end

    assign waddr = binary_wptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Self-checking bench for wr_ptr_ctrl: directed scenarios plus randomized
// traffic against an occupancy-count reference model.
module tb_wr_ptr_ctrl;

    localparam int AW   = 3;
    localparam int PW   = 4;
    localparam int SYNC = 2;
    localparam int TH   = 6;

    logic          wclk = 1'b0;
    logic          wrst_n;
    logic          w_en;
    logic          clr_ovf;
    logic [PW-1:0] gray_rptr;
    logic [PW-1:0] binary_wptr;
    logic [PW-1:0] gray_wptr;
    logic [AW-1:0] waddr;
    logic          wr_fire;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_level;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: counts of writes/reads modulo 16 plus a delay line
    int m_wcnt;
    int m_level;
    bit m_full;
    bit m_afull;
    bit m_ovf;
    int rb;
    int rq[$];

    wr_ptr_ctrl #(
        .ADDR_WIDTH(AW),
        .SYNC_STAGES(SYNC),
        .AFULL_THRESH(TH)
    ) dut (
        .wclk(wclk),
        .wrst_n(wrst_n),
        .w_en(w_en),
        .clr_ovf(clr_ovf),
        .gray_rptr(gray_rptr),
        .binary_wptr(binary_wptr),
        .gray_wptr(gray_wptr),
        .waddr(waddr),
        .wr_fire(wr_fire),
        .full(full),
        .almost_full(almost_full),
        .wr_level(wr_level),
        .overflow(overflow)
    );

    always #5 wclk = ~wclk;

    function automatic logic [PW-1:0] to_gray(input int v);
        logic [PW-1:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic set_rb(input int v);
        rb = v & 15;
        gray_rptr = to_gray(rb);
    endtask

    task automatic model_reset();
        m_wcnt = 0;
        m_level = 0;
        m_full = 0;
        m_afull = 0;
        m_ovf = 0;
        rq.delete();
        for (int i = 0; i < SYNC; i++) rq.push_front(0);
    endtask

    task automatic model_step();
        int rsync;
        bit acc;
        rsync = rq[$];
        acc = w_en && !m_full;
        m_ovf = (w_en && m_full) || (m_ovf && !clr_ovf);
        m_wcnt = (m_wcnt + int'(acc)) & 15;
        m_level = (m_wcnt - rsync) & 15;
        m_full = (m_level == 8);
        m_afull = (m_level >= TH);
        void'(rq.pop_back());
        rq.push_front(rb);
    endtask

    task automatic tick();
        @(posedge wclk);
        model_step();
        @(negedge wclk);
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        w_en = 1'b0;
        clr_ovf = 1'b0;
        set_rb(0);
        model_reset();
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        w_en = 1'b1;
        clr_ovf = 1'b0;
        set_rb(0);
        model_reset();
        #64;
        n_tests++;
        if ({binary_wptr, gray_wptr, waddr, wr_level} !== '0) begin
            n_fail++;
            $display("FAIL reset_ptrs: got %h/%h/%h/%h want 0",
                     binary_wptr, gray_wptr, waddr, wr_level);
        end
        n_tests++;
        if ({full, almost_full, overflow, wr_fire} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b%b%b%b want 0000",
                     full, almost_full, overflow, wr_fire);
        end
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    task automatic test_fill();
        w_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_tests++;
            if (wr_level !== PW'(i)) begin
                n_fail++;
                $display("FAIL fill_level[%0d]: got %0d want %0d", i, wr_level, i);
            end
            n_tests++;
            if (almost_full !== (i >= TH)) begin
                n_fail++;
                $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, i >= TH);
            end
            n_tests++;
            if (full !== (i == 8)) begin
                n_fail++;
                $display("FAIL fill_full[%0d]: got %b want %b", i, full, i == 8);
            end
        end
        n_tests++;
        if ({binary_wptr, gray_wptr, waddr} !== {4'b1000, 4'b1100, 3'b000}) begin
            n_fail++;
            $display("FAIL fill_ptrs: got %b/%b/%b want 1000/1100/000",
                     binary_wptr, gray_wptr, waddr);
        end
    endtask

    task automatic test_overflow();
        w_en = 1'b1;
        #1;
        n_tests++;
        if (wr_fire !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_fire: got %b want 0", wr_fire);
        end
        tick();
        n_tests++;
        if (binary_wptr !== 4'b1000 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: got ptr=%b ovf=%b want 1000/1", binary_wptr, overflow);
        end
        w_en = 1'b0;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: got %b want 0", overflow);
        end
    endtask

    task automatic test_sync_latency();
        set_rb(1);
        for (int e = 1; e <= 3; e++) begin
            tick();
            n_tests++;
            if (full !== (e < 3)) begin
                n_fail++;
                $display("FAIL sync_full[%0d]: got %b want %b", e, full, e < 3);
            end
        end
        n_tests++;
        if (wr_level !== 4'd7 || almost_full !== 1'b1) begin
            n_fail++;
            $display("FAIL sync_level: got %0d/%b want 7/1", wr_level, almost_full);
        end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] prev;
        w_en = 1'b0;
        for (int v = 2; v <= 8; v++) begin
            set_rb(v);
            tick();
        end
        for (int e = 0; e <= SYNC; e++) tick();
        n_tests++;
        if (wr_level !== 4'd0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_empty: got level=%0d full=%b want 0/0", wr_level, full);
        end
        w_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            prev = gray_wptr;
            tick();
            n_tests++;
            if ($countones(prev ^ gray_wptr) != 1) begin
                n_fail++;
                $display("FAIL wrap_gray[%0d]: got %b after %b want one-bit step",
                         i, gray_wptr, prev);
            end
        end
        w_en = 1'b0;
        n_tests++;
        if ({binary_wptr, gray_wptr} !== 8'h00 || full !== 1'b1 || wr_level !== 4'd8) begin
            n_fail++;
            $display("FAIL wrap_end: got %b/%b full=%b lvl=%0d want 0000/0000/1/8",
                     binary_wptr, gray_wptr, full, wr_level);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        w_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_tests++;
        if (binary_wptr !== 4'b0101) begin
            n_fail++;
            $display("FAIL arst_pre: got %b want 0101", binary_wptr);
        end
        #2;
        wrst_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({binary_wptr, gray_wptr, waddr, wr_level} !== '0 ||
            {full, almost_full, overflow} !== 3'b0) begin
            n_fail++;
            $display("FAIL arst_now: got %b/%b/%b/%0d flags=%b%b%b want all 0",
                     binary_wptr, gray_wptr, waddr, wr_level, full, almost_full, overflow);
        end
        @(negedge wclk);
        wrst_n = 1'b1;
        tick();
        n_tests++;
        if (binary_wptr !== 4'b0001) begin
            n_fail++;
            $display("FAIL arst_first: got %b want 0001", binary_wptr);
        end
    endtask

    task automatic test_ovf_collision();
        w_en = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        tick();
        n_tests++;
        if (full !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_pre: got full=%b ovf=%b want 1/1", full, overflow);
        end
        clr_ovf = 1'b1;
        tick();
        n_tests++;
        if (overflow !== 1'b1 || binary_wptr !== 4'b1000) begin
            n_fail++;
            $display("FAIL coll_win: got ovf=%b ptr=%b want 1/1000", overflow, binary_wptr);
        end
        w_en = 1'b0;
        tick();
        clr_ovf = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_clr: got %b want 0", overflow);
        end
    endtask

    task automatic test_random();
        int rd_pct;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rd_pct = (i < 200) ? 30 : 70;
            w_en = ($urandom_range(0, 99) < 60);
            clr_ovf = ($urandom_range(0, 99) < 8);
            if (((m_wcnt - rb) & 15) != 0 && $urandom_range(0, 99) < rd_pct)
                set_rb(rb + 1);
            #1;
            n_tests++;
            if (wr_fire !== (w_en && !m_full)) begin
                n_fail++;
                $display("FAIL rnd_fire[%0d]: got %b want %b", i, wr_fire, w_en && !m_full);
            end
            tick();
            n_tests++;
            if (binary_wptr !== PW'(m_wcnt) || waddr !== AW'(m_wcnt)) begin
                n_fail++;
                $display("FAIL rnd_wptr[%0d]: got %b/%b want %0d", i, binary_wptr, waddr, m_wcnt);
            end
            n_tests++;
            if (gray_wptr !== to_gray(m_wcnt)) begin
                n_fail++;
                $display("FAIL rnd_gray[%0d]: got %b want %b", i, gray_wptr, to_gray(m_wcnt));
            end
            n_tests++;
            if (wr_level !== PW'(m_level)) begin
                n_fail++;
                $display("FAIL rnd_level[%0d]: got %0d want %0d", i, wr_level, m_level);
            end
            n_tests++;
            if ({full, almost_full, overflow} !== {m_full, m_afull, m_ovf}) begin
                n_fail++;
                $display("FAIL rnd_flags[%0d]: got %b%b%b want %b%b%b", i,
                         full, almost_full, overflow, m_full, m_afull, m_ovf);
            end
        end
        w_en = 1'b0;
        clr_ovf = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_sync_latency();
        test_wrap();
        test_async_reset();
        test_ovf_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_ptr_ctrl.md
Name: wr_ptr_ctrl

Overview:
Parametrised write-domain pointer controller for the asynchronous FIFO. It replaces the fixed-width write pointer handler and adds:
- an internal read-pointer synchroniser with configurable stage count
- fill level, almost-full, an accepted-write strobe, and a sticky overflow flag

It sits in the wclk domain between the write client and the dual-port RAM. It drives the RAM write address and strobe, and exports the Gray write pointer to the read domain.

Parameters:
ADDR_WIDTH, 3, RAM address bits; depth = 2^ADDR_WIDTH; pointer width PW = ADDR_WIDTH+1; legal range ≥ 2
SYNC_STAGES, 2, flops in the gray_rptr synchroniser; legal range ≥ 2
AFULL_THRESH, 6, almost_full asserts when level ≥ this value; legal range 1..2^ADDR_WIDTH

Ports:
wclk  in  1  write clock
wrst_n  in  1  reset; asynchronous assert, active-low, clears every flop in the block
w_en  in  1  write request from client
clr_ovf  in  1  clears the sticky overflow flag
gray_rptr  in  PW  Gray read pointer from the rclk domain, asynchronous to wclk
binary_wptr  out  PW  binary write pointer, registered
gray_wptr  out  PW  Gray write pointer, registered, to the read-domain synchroniser
waddr  out  ADDR_WIDTH  RAM write address = binary_wptr[ADDR_WIDTH-1:0]
wr_fire  out  1  combinational, = w_en & ~full; RAM write strobe
full  out  1  registered full flag
almost_full  out  1  registered, level ≥ AFULL_THRESH
wr_level  out  PW  registered occupancy, 0..2^ADDR_WIDTH
overflow  out  1  sticky; set when w_en is high while full

Behaviour:
- Reset (wrst_n=0): all pointers, synchroniser stages, full, almost_full, wr_level and overflow = 0, asynchronously and with no clock edge required. The outputs hold 0 while reset is asserted, regardless of w_en.
- Synchroniser: gray_rptr → SYNC_STAGES-flop chain. rq_sync = last stage. rbin_sync = gray-to-binary(rq_sync).
- Next pointer:
  - wbin_next = binary_wptr + wr_fire, modulo 2^PW, wrapping 1111→0000 for PW=4.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - binary_wptr and gray_wptr load wbin_next and wgray_next on every edge.
- Full: full_next = (wgray_next == {~rq_sync[PW-1:PW-2], rq_sync[PW-3:0]}), registered.
- Level and almost-full:
  - wr_level_next = wbin_next − rbin_sync, modulo 2^PW.
  - almost_full_next = (wr_level_next ≥ AFULL_THRESH).
  - Both registered.
- Latency, write side: an accepted write updates pointers, full, wr_level and almost_full on the same edge.
- Latency, read side: a gray_rptr change is reflected in full, wr_level and almost_full after SYNC_STAGES+1 wclk edges. Full and level are therefore pessimistic and never optimistic.
- Write while full: the write is dropped, pointers are unchanged, and wr_fire=0. overflow = 1 from the next edge.
- overflow clear:
  - overflow is cleared by clr_ovf=1 at an edge.
  - A new overflow event in the same cycle wins, and overflow stays 1.
- Simultaneous write and read-pointer advance: both apply. The level is computed from the post-write pointer and the current rq_sync.
- gray_rptr is assumed to change at most one bit per rclk; the block performs no glitch checking.

Test Plan (ADDR_WIDTH=3, SYNC_STAGES=2, AFULL_THRESH=6, PW=4):
1. wrst_n=0 for 64 ns with w_en=1 → all outputs 0. Release, gray_rptr=0000, w_en=1 for 8 edges:
   - binary_wptr=1000, gray_wptr=1100, waddr=000, wr_level=8, full=1 after the 8th edge.
   - almost_full=1 from the edge where wr_level=6.
2. Continue w_en=1 while full → binary_wptr stays 1000, wr_fire=0, overflow=1 on the next edge. Pulse clr_ovf with w_en=0 → overflow=0.
3. From full, drive gray_rptr=0001 → full=0 and wr_level=7 exactly 3 wclk edges later; almost_full stays 1.
4. Wrap-around: gray_rptr=1100 (binary 8) synced, wptr=1000 → 8 writes:
   - binary_wptr=0000, gray_wptr=0000, full=1, wr_level=8.
   - Gray sequence checked for a single-bit change per write.
5. Assert wrst_n low mid-cycle at binary_wptr=0101 → all outputs 0 immediately, before the next wclk edge. After release, the first write gives binary_wptr=0001.
6. While full with overflow already 1: assert clr_ovf and w_en in the same cycle → overflow remains 1. Next cycle, clr_ovf alone → overflow=0.
